// File: rtl/riscv_mc_ctrl_if.sv
// Memory handshake between the multicycle control unit and the unified
// instruction/data memory.
interface riscv_mc_ctrl_if;
  logic mem_req_o;
  logic mem_write_o;
  logic adr_src_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_write_o,
    output adr_src_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_write_o,
    input  adr_src_o,
    output mem_ready_i
  );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RISC-V control unit: Moore sequencer for the shared datapath,
// combinational ALU decoder, memory ready handshake and wait watchdog.
module riscv_mc_ctrl #(
  parameter int MaxWait = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [6:0]             op_i,
  input  logic [2:0]             funct3_i,
  input  logic [6:0]             funct7_i,
  input  logic                   zero_i,
  riscv_mc_ctrl_if.master        mem,
  output logic                   ir_write_o,
  output logic                   pc_write_o,
  output logic                   reg_write_o,
  output logic [1:0]             alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [2:0]             alu_control_o,
  output logic [2:0]             imm_src_o,
  output logic [1:0]             result_src_o,
  output logic                   illegal_o,
  output logic                   bus_err_o
);

  localparam int CntW = $clog2(MaxWait + 1);

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI, TRAP
  } state_t;

  state_t          state, state_n;
  logic [CntW-1:0] wait_cnt;
  logic            waiting;
  logic            set_ill, set_berr;
  logic            mem_req_raw, mem_write_raw, ir_write_raw;
  logic            pc_write_raw, reg_write_raw;

  // funct7 carries only the add/sub selector bit for this subset
  logic unused_f7;
  assign unused_f7 = ^{funct7_i[6], funct7_i[4:0]};

  // add vs sub depends on op[5] so that addi with imm[10] set stays an add
  function automatic logic [2:0] alu_dec(input logic op5, input logic [2:0] f3,
                                         input logic f75);
    case (f3)
      3'b000:  alu_dec = (op5 & f75) ? AluSub : AluAdd;
      3'b010:  alu_dec = AluSlt;
      3'b110:  alu_dec = AluOr;
      3'b111:  alu_dec = AluAnd;
      default: alu_dec = AluAdd;
    endcase
  endfunction

  function automatic logic f3_supported(input logic [2:0] f3);
    f3_supported = (f3 == 3'b000) || (f3 == 3'b010) ||
                   (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FETCH;
    else         state <= state_n;
  end

  // wait watchdog: restarts on every state change or completed access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    wait_cnt <= '0;
    else if ((state_n != state) || mem.mem_ready_i) wait_cnt <= '0;
    else if (waiting)                               wait_cnt <= wait_cnt + CntW'(1);
  end

  // sticky trap flags, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      illegal_o <= illegal_o | set_ill;
      bus_err_o <= bus_err_o | set_berr;
    end
  end

  // next-state and Moore outputs (ready/zero gate only the PC/IR loads)
  always_comb begin
    state_n       = state;
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem.adr_src_o = 1'b0;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_control_o = AluAdd;
    imm_src_o     = 3'b000;
    result_src_o  = 2'b00;
    waiting       = 1'b0;
    set_ill       = 1'b0;
    set_berr      = 1'b0;
    case (state)
      FETCH: begin
        mem_req_raw  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_raw = mem.mem_ready_i;
        pc_write_raw = mem.mem_ready_i;
        if (mem.mem_ready_i) state_n = DECODE;
        else                 waiting = 1'b1;
      end
      DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = 3'b010;
        case (op_i)
          7'b0000011, 7'b0100011: state_n = MEMADR;
          7'b0110011: state_n = f3_supported(funct3_i) ? EXECUTER : TRAP;
          7'b0010011: state_n = f3_supported(funct3_i) ? EXECUTEI : TRAP;
          7'b1100011: state_n = (funct3_i == 3'b000) ? BEQ : TRAP;
          7'b1101111: state_n = JAL;
          7'b0110111: state_n = LUI;
          default:    state_n = TRAP;
        endcase
        set_ill = (state_n == TRAP);
      end
      MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = op_i[5] ? 3'b001 : 3'b000;
        state_n     = op_i[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_raw   = 1'b1;
        mem.adr_src_o = 1'b1;
        if (mem.mem_ready_i) state_n = MEMWB;
        else                 waiting = 1'b1;
      end
      MEMWB: begin
        result_src_o  = 2'b01;
        reg_write_raw = 1'b1;
        state_n       = FETCH;
      end
      MEMWRITE: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        mem.adr_src_o = 1'b1;
        if (mem.mem_ready_i) state_n = FETCH;
        else                 waiting = 1'b1;
      end
      EXECUTER: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = alu_dec(op_i[5], funct3_i, funct7_i[5]);
        state_n       = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_dec(op_i[5], funct3_i, funct7_i[5]);
        state_n       = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        state_n       = FETCH;
      end
      BEQ: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = AluSub;
        pc_write_raw  = zero_i;
        state_n       = FETCH;
      end
      JAL: begin
        alu_src_a_o  = 2'b01;
        alu_src_b_o  = 2'b10;
        pc_write_raw = 1'b1;
        state_n      = ALUWB;
      end
      LUI: begin
        imm_src_o     = 3'b011;
        result_src_o  = 2'b11;
        reg_write_raw = 1'b1;
        state_n       = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = TRAP;
    endcase
    if (waiting && (wait_cnt == CntW'(MaxWait - 1))) begin
      state_n  = TRAP;
      set_berr = 1'b1;
    end
  end

  // enables are held off for the whole time reset is asserted
  assign mem.mem_req_o   = mem_req_raw   & rst_ni;
  assign mem.mem_write_o = mem_write_raw & rst_ni;
  assign ir_write_o      = ir_write_raw  & rst_ni;
  assign pc_write_o      = pc_write_raw  & rst_ni;
  assign reg_write_o     = reg_write_raw & rst_ni;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: stimulus pushes the expected control
// word for each cycle, a negedge monitor pops and compares.
module tb_riscv_mc_ctrl;

  typedef struct packed {
    logic       req, wr, adr, ir, pc, rw;
    logic [1:0] a, b;
    logic [2:0] ctl, imm;
    logic [1:0] res;
    logic       ill, berr;
  } ctl_t;

  typedef struct packed {
    logic sel;
    ctl_t e;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, rst2_n = 1'b0;
  logic [6:0] op = '0, f7 = '0, nop = '0, nf7 = '0;
  logic [2:0] f3 = '0, nf3 = '0;
  logic       zero = 1'b0, rdy1 = 1'b1, rdy2 = 1'b0;
  logic       exp_ill = 1'b0, exp_berr = 1'b0;

  rec_t  exp_q[$];
  string nm_q[$];
  int    checks = 0, failures = 0;
  int    xchecks = 0, xfails = 0;

  riscv_mc_ctrl_if bus1 ();
  riscv_mc_ctrl_if bus2 ();
  assign bus1.mem_ready_i = rdy1;
  assign bus2.mem_ready_i = rdy2;

  logic       ir1, pc1, rw1, ill1, be1, ir2, pc2, rw2, ill2, be2;
  logic [1:0] a1, b1, res1, a2, b2, res2;
  logic [2:0] ctl1, imm1, ctl2, imm2;

  riscv_mc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(f3), .funct7_i(f7),
    .zero_i(zero), .mem(bus1.master), .ir_write_o(ir1), .pc_write_o(pc1),
    .reg_write_o(rw1), .alu_src_a_o(a1), .alu_src_b_o(b1),
    .alu_control_o(ctl1), .imm_src_o(imm1), .result_src_o(res1),
    .illegal_o(ill1), .bus_err_o(be1)
  );

  riscv_mc_ctrl #(.MaxWait(4)) dut_to (
    .clk_i(clk), .rst_ni(rst2_n), .op_i(op), .funct3_i(f3), .funct7_i(f7),
    .zero_i(zero), .mem(bus2.master), .ir_write_o(ir2), .pc_write_o(pc2),
    .reg_write_o(rw2), .alu_src_a_o(a2), .alu_src_b_o(b2),
    .alu_control_o(ctl2), .imm_src_o(imm2), .result_src_o(res2),
    .illegal_o(ill2), .bus_err_o(be2)
  );

  ctl_t act1, act2;
  assign act1 = {bus1.mem_req_o, bus1.mem_write_o, bus1.adr_src_o, ir1, pc1, rw1,
                 a1, b1, ctl1, imm1, res1, ill1, be1};
  assign act2 = {bus2.mem_req_o, bus2.mem_write_o, bus2.adr_src_o, ir2, pc2, rw2,
                 a2, b2, ctl2, imm2, res2, ill2, be2};

  function automatic ctl_t mk(input logic req, wr, adr, ir, pc, rw,
                              input logic [1:0] a, b, input logic [2:0] ctl, imm,
                              input logic [1:0] res);
    ctl_t e;
    e = '{req:req, wr:wr, adr:adr, ir:ir, pc:pc, rw:rw, a:a, b:b,
          ctl:ctl, imm:imm, res:res, ill:1'b0, berr:1'b0};
    return e;
  endfunction

  // hand-written expected control words per state
  function automatic ctl_t e_fetch(input logic r);
    return mk(1, 0, 0, r, r, 0, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10);
  endfunction
  function automatic ctl_t e_exr(input logic [2:0] c);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, c, 3'b000, 2'b00);
  endfunction
  function automatic ctl_t e_exi(input logic [2:0] c);
    return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, c, 3'b000, 2'b00);
  endfunction
  function automatic ctl_t e_beq(input logic z);
    return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00);
  endfunction

  ctl_t E_RST, E_DEC, E_MADR_LW, E_MADR_SW, E_MRD, E_MWB, E_MWR, E_AWB, E_JAL, E_LUI, E_TRAP;
  initial begin
    E_RST     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10);
    E_DEC     = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 3'b010, 2'b00);
    E_MADR_LW = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00);
    E_MADR_SW = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00);
    E_MRD     = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
    E_MWB     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01);
    E_MWR     = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
    E_AWB     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
    E_JAL     = mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 3'b000, 2'b00);
    E_LUI     = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b011, 2'b11);
    E_TRAP    = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
  end

  task automatic set_instr(input logic [31:0] ins);
    nop = ins[6:0];
    nf3 = ins[14:12];
    nf7 = ins[31:25];
  endtask

  // one clock cycle of stimulus plus the expected outputs for that cycle
  task automatic step(input logic sel, input logic rv, input logic rdy,
                      input logic z, input ctl_t e, input string nm);
    rec_t r;
    @(posedge clk);
    #1;
    op = nop; f3 = nf3; f7 = nf7; zero = z;
    if (!sel) begin rst_n = rv; rdy1 = rdy; end
    else      begin rst2_n = rv; rdy2 = rdy; end
    e.ill  = exp_ill;
    e.berr = exp_berr;
    r.sel  = sel;
    r.e    = e;
    exp_q.push_back(r);
    nm_q.push_back(nm);
  endtask

  // monitor: compare whatever the stimulus expected for this cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      automatic rec_t  r  = exp_q.pop_front();
      automatic string nm = nm_q.pop_front();
      automatic ctl_t  a  = r.sel ? act2 : act1;
      checks <= checks + 1;
      if (a !== r.e) begin
        failures <= failures + 1;
        $display("FAIL %s actual=%h expected=%h", nm, a, r.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 0, 1, 0, E_RST, "reset_hold");
    // lw x5,4(x0): five cycles, single write-back from memory data
    set_instr(32'h00402283);
    step(0, 1, 1, 0, e_fetch(1), "lw_fetch");
    step(0, 1, 1, 0, E_DEC, "lw_decode");
    step(0, 1, 1, 0, E_MADR_LW, "lw_memadr");
    step(0, 1, 1, 0, E_MRD, "lw_memread");
    step(0, 1, 1, 0, E_MWB, "lw_memwb");
    // sw with three wait cycles in MEMWRITE
    set_instr(32'h00502423);
    step(0, 1, 1, 0, e_fetch(1), "sw_fetch");
    step(0, 1, 1, 0, E_DEC, "sw_decode");
    step(0, 1, 1, 0, E_MADR_SW, "sw_memadr");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, E_MWR, "sw_memwrite_wait");
    step(0, 1, 1, 0, E_MWR, "sw_memwrite_done");
    // R-type add / sub / slt / and
    set_instr(32'h002081B3);
    step(0, 1, 1, 0, e_fetch(1), "add_fetch");
    step(0, 1, 1, 0, E_DEC, "add_decode");
    step(0, 1, 1, 0, e_exr(3'b000), "add_exec");
    step(0, 1, 1, 0, E_AWB, "add_aluwb");
    set_instr(32'h402081B3);
    step(0, 1, 1, 0, e_fetch(1), "sub_fetch");
    step(0, 1, 1, 0, E_DEC, "sub_decode");
    step(0, 1, 1, 0, e_exr(3'b001), "sub_exec");
    step(0, 1, 1, 0, E_AWB, "sub_aluwb");
    set_instr(32'h0020A1B3);
    step(0, 1, 1, 0, e_fetch(1), "slt_fetch");
    step(0, 1, 1, 0, E_DEC, "slt_decode");
    step(0, 1, 1, 0, e_exr(3'b101), "slt_exec");
    step(0, 1, 1, 0, E_AWB, "slt_aluwb");
    set_instr(32'h0020F1B3);
    step(0, 1, 1, 0, e_fetch(1), "and_fetch");
    step(0, 1, 1, 0, E_DEC, "and_decode");
    step(0, 1, 1, 0, e_exr(3'b010), "and_exec");
    step(0, 1, 1, 0, E_AWB, "and_aluwb");
    // I-type ori, and addi whose imm[10] must not turn it into a sub
    set_instr(32'h0050E193);
    step(0, 1, 1, 0, e_fetch(1), "ori_fetch");
    step(0, 1, 1, 0, E_DEC, "ori_decode");
    step(0, 1, 1, 0, e_exi(3'b011), "ori_exec");
    step(0, 1, 1, 0, E_AWB, "ori_aluwb");
    set_instr(32'h40008193);
    step(0, 1, 1, 0, e_fetch(1), "addi_fetch");
    step(0, 1, 1, 0, E_DEC, "addi_decode");
    step(0, 1, 1, 0, e_exi(3'b000), "addi_exec");
    step(0, 1, 1, 0, E_AWB, "addi_aluwb");
    // beq taken and not taken
    set_instr(32'h00000463);
    step(0, 1, 1, 0, e_fetch(1), "beq_t_fetch");
    step(0, 1, 1, 0, E_DEC, "beq_t_decode");
    step(0, 1, 1, 1, e_beq(1), "beq_taken");
    step(0, 1, 1, 0, e_fetch(1), "beq_n_fetch");
    step(0, 1, 1, 0, E_DEC, "beq_n_decode");
    step(0, 1, 1, 0, e_beq(0), "beq_not_taken");
    // jal
    set_instr(32'h0080006F);
    step(0, 1, 1, 0, e_fetch(1), "jal_fetch");
    step(0, 1, 1, 0, E_DEC, "jal_decode");
    step(0, 1, 1, 0, E_JAL, "jal_exec");
    step(0, 1, 1, 0, E_AWB, "jal_aluwb");
    // lui with one fetch wait cycle
    set_instr(32'h123452B7);
    step(0, 1, 0, 0, e_fetch(0), "lui_fetch_wait");
    step(0, 1, 1, 0, e_fetch(1), "lui_fetch");
    step(0, 1, 1, 0, E_DEC, "lui_decode");
    step(0, 1, 1, 0, E_LUI, "lui_wb");
    // asynchronous reset in the middle of a waiting MEMREAD
    set_instr(32'h00402283);
    step(0, 1, 1, 0, e_fetch(1), "rst_lw_fetch");
    step(0, 1, 1, 0, E_DEC, "rst_lw_decode");
    step(0, 1, 1, 0, E_MADR_LW, "rst_lw_memadr");
    step(0, 1, 0, 0, E_MRD, "rst_lw_memread_wait");
    step(0, 0, 0, 0, E_RST, "rst_async_enables_off");
    step(0, 1, 0, 0, e_fetch(0), "rst_release_fetch");
    // illegal opcode traps and stays trapped
    set_instr(32'h0000007F);
    step(0, 1, 1, 0, e_fetch(1), "ill_fetch");
    step(0, 1, 1, 0, E_DEC, "ill_decode");
    exp_ill = 1'b1;
    step(0, 1, 1, 0, E_TRAP, "ill_trap");
    step(0, 1, 1, 1, E_TRAP, "ill_trap_hold");
    // reset clears the sticky flag; unsupported R funct3 also traps
    exp_ill = 1'b0;
    step(0, 0, 1, 0, E_RST, "rst_clear_ill");
    set_instr(32'h002091B3);
    step(0, 1, 1, 0, e_fetch(1), "sll_fetch");
    step(0, 1, 1, 0, E_DEC, "sll_decode");
    exp_ill = 1'b1;
    step(0, 1, 1, 0, E_TRAP, "sll_trap");
    // watchdog with MaxWait=4: four waiting fetch cycles, then bus error
    exp_ill = 1'b0;
    set_instr(32'h00000013);
    step(1, 0, 0, 0, E_RST, "to_reset");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, e_fetch(0), "to_fetch_wait");
    exp_berr = 1'b1;
    step(1, 1, 0, 0, E_TRAP, "to_bus_err_trap");
    step(1, 1, 1, 0, E_TRAP, "to_bus_err_hold");
    @(negedge clk);
    xchecks = xchecks + 1;
    if (be2 !== 1'b1 || bus2.mem_req_o !== 1'b0 || bus2.mem_write_o !== 1'b0 ||
        ir2 !== 1'b0 || pc2 !== 1'b0 || rw2 !== 1'b0) begin
      xfails = xfails + 1;
      $display("FAIL final_bus_err_state be=%b req=%b wr=%b ir=%b pc=%b rw=%b",
               be2, bus2.mem_req_o, bus2.mem_write_o, ir2, pc2, rw2);
    end
    xchecks = xchecks + 1;
    if (ill1 !== 1'b1 || be1 !== 1'b0 || bus1.mem_req_o !== 1'b0 ||
        rw1 !== 1'b0 || pc1 !== 1'b0) begin
      xfails = xfails + 1;
      $display("FAIL final_illegal_state ill=%b be=%b req=%b rw=%b pc=%b",
               ill1, be1, bus1.mem_req_o, rw1, pc1);
    end
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks + xchecks, failures + xfails);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Control unit for the multicycle RISC-V core. It sequences the shared datapath (one ALU, one unified instruction/data memory, regfile) over several cycles per instruction. It is a Moore FSM plus a combinational ALU decoder, with a ready handshake toward memory and a wait-timeout watchdog. It sits beside the multicycle datapath and drives all its enables and mux selects.

Parameters:
MaxWait, 255, max cycles a memory access may wait for mem_ready_i before the bus-error trap; counter width is $clog2(MaxWait+1)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
op_i  input  7  Instr[6:0] from the instruction register
funct3_i  input  3  Instr[14:12]
funct7_i  input  7  Instr[31:25]
zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory access completes this cycle
mem_req_o  output  1  memory access requested
mem_write_o  output  1  memory write strobe
adr_src_o  output  1  address select: 0 = PC, 1 = Result
ir_write_o  output  1  instruction register / OldPC load
pc_write_o  output  1  PC load
reg_write_o  output  1  regfile write enable
alu_src_a_o  output  2  select: 00 = PC, 01 = OldPC, 10 = rs1
alu_src_b_o  output  2  select: 00 = rs2, 01 = ImmExt, 10 = 4
alu_control_o  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src_o  output  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J
result_src_o  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
illegal_o  output  1  sticky: illegal instruction trapped
bus_err_o  output  1  sticky: memory timeout trapped

Behaviour:
- Reset: rst_ni low asynchronously sets state FETCH, clears the wait counter, illegal_o and bus_err_o. While rst_ni is low, every enable (mem_req, mem_write, ir_write, pc_write, reg_write) is forced to 0.
- Outputs are functions of state only, except pc_write_o (uses zero_i), and ir_write/pc_write in FETCH (gated by mem_ready_i). alu_control_o also decodes funct3_i/funct7_i in EXECUTER/EXECUTEI.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write and pc_write equal mem_ready_i.
  - Go to DECODE when mem_ready_i is high; otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 with funct3=000 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other op or funct3 -> TRAP, setting illegal_o
  - supported R/I funct3: 000, 010, 110, 111
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=000 for lw, 001 for sw. Next MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Go to MEMWB on mem_ready_i.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Go to FETCH on mem_ready_i.
- EXECUTER: alu_src_a=10, alu_src_b=00, decoded op, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, imm_src=000, decoded op, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero_i, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB.
- LUI: imm_src=011, result_src=11, reg_write=1, then FETCH.
- ALU decode: funct3 000 gives sub iff op[5] & funct7[5], else add; 010 slt; 110 or; 111 and.
- Wait counter:
  - Clears on entering FETCH, MEMREAD or MEMWRITE, and on any ready.
  - Increments each waiting cycle.
  - Reaching MaxWait without ready -> TRAP, setting bus_err_o.
- TRAP: all enables 0, absorbing until reset.
- Cycle counts with ready on first cycle: lw 5, sw 4, R/I 4, jal 4, beq 3, lui 3.

Test Plan:
- Reset mid-MEMREAD (rst_ni low for 1 cycle asynchronously) -> enables 0 immediately; after release, FETCH with mem_req=1, illegal_o=0.
- Instr 0x00402283 (lw x5,4(x0)), ready always 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src=01.
- 0x00502423 (sw) with mem_ready_i held low 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then FETCH; reg_write never 1.
- 0x002081B3 (add) -> alu_control 000; with funct7=0x20 (sub) -> 001; funct3=010 -> 101; ALUWB reg_write=1 in cycle 4.
- 0x00000463 (beq): zero_i=1 -> pc_write=1 in BEQ; zero_i=0 -> pc_write=0; total 3 cycles.
- op 0x7F -> TRAP, illegal_o=1. Separately, with MaxWait=4 and mem_ready_i=0 in FETCH -> bus_err_o=1 after 4 waiting cycles, all enables 0.
